// File: rtl/matmul_pkg.sv
// Shared types and constants for the output-stationary systolic matmul array.
// Holds the default array geometry, the feeder FSM state type, the
// sign-magnitude element layout and the flush-length helper.
package matmul_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    // Sign-magnitude element: bit DW-1 is the sign, the rest is the magnitude.
    // 0x80 (negative zero) is a legal encoding and means magnitude 0.
    typedef struct packed {
        logic              sign;
        logic [DW_DEF-2:0] mag;
    } sm_elem_t;

    // Zero-beats needed after the last real beat: N-1 to drain the skew,
    // N-1 to cross the array columns, and 1 for the final accumulate.
    function automatic int FLUSH_LEN(input int n);
        return 2 * (n - 1) + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the input skew: a DEPTH-stage shift register that moves only
// on adv. Lane i is built with DEPTH = i+1, so an element entering at advance
// step s reaches the output after advance step s+i.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stages [DEPTH];

    // Shift the whole line by one stage on every advance; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                stages[j] <= '0;
            end
        end else if (adv) begin
            stages[0] <= din;
            for (int j = 1; j < DEPTH; j++) begin
                stages[j] <= stages[j-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// West-edge feeder for the systolic matmul array. Accepts one A column-slice
// per beat over a valid/ready stream, skews lane i by i advances, drives the
// global PE enable and then flushes zeros until every PE has accumulated.
// Optional build macro FEEDER_STALL_CNT_EN adds a saturating stall counter.
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready depends only on the FSM state, and
// in_data must be stable while in_valid is high.
module systolic_feeder
    import matmul_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int KMAX = 16,
    parameter int CW   = $clog2(KMAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic [N*DW-1:0] out_data,
    output logic            pe_en,
    output logic            busy,
    output logic            done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int F  = FLUSH_LEN(N);
    localparam int FW = $clog2(F + 1);

    // state is kept as a plain named signal so checkers can bind to it.
    feeder_state_t   state;
    feeder_state_t   state_next;
    logic [CW-1:0]   k_reg;
    logic [CW-1:0]   beat_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [CW-1:0]   k_clamped;
    logic            adv;
    logic            accept;
    logic [N*DW-1:0] lane_in;

    // Oversized job lengths are clamped to the array's inner-dimension limit.
    always_comb begin
        k_clamped = (k_len > CW'(KMAX)) ? CW'(KMAX) : k_len;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the state-decoded handshake and advance strobe.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        adv        = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (k_clamped == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                in_ready = 1'b1;
                adv      = in_valid;
                if (in_valid && (beat_cnt == k_reg - 1'b1)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                adv = 1'b1;
                if (flush_cnt == FW'(F - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Zeros are shifted in everywhere except while streaming real beats.
    always_comb begin
        lane_in = (state == STREAM) ? in_data : '0;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Job length capture and beat/flush progress counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else if (accept) begin
            k_reg     <= k_clamped;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == STREAM && adv) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // PEs sample out_data exactly once per advance, in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_en <= 1'b0;
        end else begin
            pe_en <= adv;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    // Count STREAM cycles without a valid beat; cleared when a job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (state == STREAM && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_line (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .din  (lane_in[i*DW +: DW]),
            .dout (out_data[i*DW +: DW])
        );
    end

endmodule
